// File: rtl/svc_pkg.sv
// svc_pkg: service cost/time tables, FSM state encoding and mask helpers
// shared by the service executor block.
`default_nettype none

package svc_pkg;

  localparam int NUM_SVC = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef logic [2:0]           svc_idx_t;
  typedef logic [0:NUM_SVC-1]   svc_mask_t;

  function automatic logic [6:0] svc_cost(input svc_idx_t idx);
    case (idx)
      3'd0:    svc_cost = 7'd10;
      3'd1:    svc_cost = 7'd20;
      3'd2:    svc_cost = 7'd5;
      3'd3:    svc_cost = 7'd30;
      3'd4:    svc_cost = 7'd15;
      3'd5:    svc_cost = 7'd25;
      default: svc_cost = 7'd0;
    endcase
  endfunction

  function automatic logic [2:0] svc_time(input svc_idx_t idx);
    case (idx)
      3'd0:    svc_time = 3'd2;
      3'd1:    svc_time = 3'd3;
      3'd2:    svc_time = 3'd1;
      3'd3:    svc_time = 3'd4;
      3'd4:    svc_time = 3'd2;
      3'd5:    svc_time = 3'd3;
      default: svc_time = 3'd1;
    endcase
  endfunction

  // Mask bit i (bit 0 is the MSB side) corresponds to service i.
  function automatic svc_mask_t svc_onehot(input svc_idx_t idx);
    svc_onehot = '0;
    for (int i = 0; i < NUM_SVC; i++) begin
      if (idx == svc_idx_t'(i)) svc_onehot[i] = 1'b1;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/svc_prio_enc.sv
// svc_prio_enc: combinational lowest-index set-bit encoder for a service mask.
`default_nettype none

module svc_prio_enc
  import svc_pkg::*;
(
  input  logic [0:NUM_SVC-1] mask_i,
  output logic [2:0]         idx_o,
  output logic               valid_o
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_SVC - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = svc_idx_t'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/service_executor.sv
// service_executor: runs the selected services in index order, accumulating
// cost and time, with abort support and registered done/aborted pulses.
`default_nettype none

module service_executor
  import svc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [0:5]       req_sel,
  output logic             req_ready,
  input  logic             abort,
  output logic             busy,
  output logic [0:5]       svc_active,
  output logic [2:0]       time_left,
  output logic             done,
  output logic             aborted,
  output logic [0:6]       total_cost,
  output logic [0:4]       total_time
);

  logic [1:0]  state_q, state_d;
  svc_mask_t   pend_q, pend_d;
  logic [2:0]  elap_q, elap_d;
  logic [6:0]  cost_q, cost_d;
  logic [4:0]  time_q, time_d;
  logic        done_q, done_d;
  logic        abrt_q, abrt_d;

  svc_idx_t    cur_idx;
  logic        cur_valid;
  logic        in_run;
  logic        last_cycle;

  svc_prio_enc u_prio_enc (
    .mask_i  (pend_q),
    .idx_o   (cur_idx),
    .valid_o (cur_valid)
  );

  assign in_run     = (state_q == ST_RUN) && cur_valid;
  assign last_cycle = (elap_q == (svc_time(cur_idx) - 3'd1));

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    elap_d  = elap_q;
    cost_d  = cost_q;
    time_d  = time_q;
    done_d  = 1'b0;
    abrt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          pend_d  = req_sel;
          elap_d  = '0;
          cost_d  = '0;
          time_d  = '0;
          state_d = (req_sel != '0) ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        // Abort beats completion: the partial service is never credited.
        if (abort) begin
          state_d = ST_IDLE;
          pend_d  = '0;
          elap_d  = '0;
          abrt_d  = 1'b1;
        end else if (last_cycle) begin
          pend_d = pend_q & ~svc_onehot(cur_idx);
          cost_d = cost_q + svc_cost(cur_idx);
          time_d = time_q + {2'b00, svc_time(cur_idx)};
          elap_d = '0;
          if (pend_d == '0) state_d = ST_FIN;
        end else begin
          elap_d = elap_q + 3'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      elap_q  <= '0;
      cost_q  <= '0;
      time_q  <= '0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      elap_q  <= elap_d;
      cost_q  <= cost_d;
      time_q  <= time_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign svc_active = in_run ? svc_onehot(cur_idx) : '0;
  assign time_left  = in_run ? (svc_time(cur_idx) - elap_q) : 3'd0;
  assign done       = done_q;
  assign aborted    = abrt_q;
  assign total_cost = cost_q;
  assign total_time = time_q;

endmodule

`default_nettype wire

// File: tb/tb_service_executor.sv
// tb_service_executor: directed self-checking bench for service_executor.
`default_nettype none

module tb_service_executor;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [0:5] req_sel;
  logic       req_ready;
  logic       abort;
  logic       busy;
  logic [0:5] svc_active;
  logic [2:0] time_left;
  logic       done;
  logic       aborted;
  logic [0:6] total_cost;
  logic [0:4] total_time;

  int total = 0;
  int bad   = 0;

  service_executor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .abort      (abort),
    .busy       (busy),
    .svc_active (svc_active),
    .time_left  (time_left),
    .done       (done),
    .aborted    (aborted),
    .total_cost (total_cost),
    .total_time (total_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns #1 after the accepting edge.
  task automatic send(input logic [0:5] sel);
    req_valid = 1'b1;
    req_sel   = sel;
    step();
    req_valid = 1'b0;
    req_sel   = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({req_ready, busy, svc_active, time_left, done, aborted} !== {1'b1, 1'b0, 6'b0, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_ctrl: rdy=%b busy=%b act=%b tl=%0d done=%b abt=%b want rdy=1 others 0",
               req_ready, busy, svc_active, time_left, done, aborted);
    end
    total++;
    if (total_cost !== 7'd0 || total_time !== 5'd0) begin
      bad++;
      $display("FAIL reset_totals: cost=%0d time=%0d want 0/0", total_cost, total_time);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: rdy=%b busy=%b want 1/0", req_ready, busy);
    end
  endtask

  task automatic test_zero_mask();
    send(6'b000000);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || svc_active !== 6'b0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL zero_fin_cycle: done=%b busy=%b act=%b rdy=%b want 0/0/000000/0",
               done, busy, svc_active, req_ready);
    end
    step();
    total++;
    if (done !== 1'b1 || svc_active !== 6'b0 || total_cost !== 7'd0 || total_time !== 5'd0) begin
      bad++;
      $display("FAIL zero_done: done=%b act=%b cost=%0d time=%0d want 1/000000/0/0",
               done, svc_active, total_cost, total_time);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL zero_done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_single_ignore();
    send(6'b100000);
    total++;
    if (svc_active !== 6'b100000 || time_left !== 3'd2 || busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_c0: act=%b tl=%0d busy=%b rdy=%b want 100000/2/1/0",
               svc_active, time_left, busy, req_ready);
    end
    req_valid = 1'b1;
    req_sel   = 6'b111111;
    step();
    total++;
    if (svc_active !== 6'b100000 || time_left !== 3'd1) begin
      bad++;
      $display("FAIL single_c1: act=%b tl=%0d want 100000/1", svc_active, time_left);
    end
    step();
    total++;
    if (busy !== 1'b0 || req_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL single_fin: busy=%b rdy=%b done=%b want 0/0/0", busy, req_ready, done);
    end
    req_valid = 1'b0;
    req_sel   = '0;
    step();
    total++;
    if (done !== 1'b1 || total_cost !== 7'd10 || total_time !== 5'd2 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_done: done=%b cost=%0d time=%0d rdy=%b want 1/10/2/1",
               done, total_cost, total_time, req_ready);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || total_cost !== 7'd10 || total_time !== 5'd2) begin
      bad++;
      $display("FAIL single_hold: done=%b busy=%b cost=%0d time=%0d want 0/0/10/2",
               done, busy, total_cost, total_time);
    end
  endtask

  task automatic test_all_services();
    int         times [6] = '{2, 3, 1, 4, 2, 3};
    logic [0:5] exp_act;
    int         seq_bad;
    send(6'b111111);
    total++;
    if (total_cost !== 7'd0 || total_time !== 5'd0) begin
      bad++;
      $display("FAIL all_clear: cost=%0d time=%0d want 0/0", total_cost, total_time);
    end
    seq_bad = 0;
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < times[s]; k++) begin
        exp_act = 6'b100000 >> s;
        total++;
        if (svc_active !== exp_act || time_left !== 3'(times[s] - k) || done !== 1'b0) begin
          bad++;
          seq_bad++;
          if (seq_bad < 4)
            $display("FAIL all_seq s%0d k%0d: act=%b tl=%0d done=%b want %b/%0d/0",
                     s, k, svc_active, time_left, done, exp_act, times[s] - k);
        end
        step();
      end
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || svc_active !== 6'b0) begin
      bad++;
      $display("FAIL all_fin: busy=%b done=%b act=%b want 0/0/000000", busy, done, svc_active);
    end
    step();
    total++;
    if (done !== 1'b1 || total_cost !== 7'b1101001 || total_time !== 5'b01111) begin
      bad++;
      $display("FAIL all_done: done=%b cost=%0d time=%0d want 1/105/15", done, total_cost, total_time);
    end
    step();
  endtask

  task automatic test_abort_mid();
    send(6'b010100);
    repeat (4) step();
    total++;
    if (svc_active !== 6'b000100 || time_left !== 3'd3) begin
      bad++;
      $display("FAIL abort_mid_pos: act=%b tl=%0d want 000100/3", svc_active, time_left);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (aborted !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_mid_pulse: abt=%b done=%b busy=%b rdy=%b want 1/0/0/1",
               aborted, done, busy, req_ready);
    end
    total++;
    if (total_cost !== 7'd20 || total_time !== 5'd3) begin
      bad++;
      $display("FAIL abort_mid_totals: cost=%0d time=%0d want 20/3", total_cost, total_time);
    end
    step();
    total++;
    if (aborted !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_mid_after: abt=%b done=%b want 0/0", aborted, done);
    end
  endtask

  task automatic test_abort_last();
    send(6'b001001);
    total++;
    if (svc_active !== 6'b001000 || time_left !== 3'd1) begin
      bad++;
      $display("FAIL abort_last_s2: act=%b tl=%0d want 001000/1", svc_active, time_left);
    end
    repeat (3) step();
    total++;
    if (svc_active !== 6'b000001 || time_left !== 3'd1) begin
      bad++;
      $display("FAIL abort_last_pos: act=%b tl=%0d want 000001/1", svc_active, time_left);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (aborted !== 1'b1 || done !== 1'b0 || total_cost !== 7'd5 || total_time !== 5'd1) begin
      bad++;
      $display("FAIL abort_last: abt=%b done=%b cost=%0d time=%0d want 1/0/5/1",
               aborted, done, total_cost, total_time);
    end
    repeat (2) begin
      step();
      total++;
      if (done !== 1'b0 || aborted !== 1'b0) begin
        bad++;
        $display("FAIL abort_last_after: done=%b abt=%b want 0/0", done, aborted);
      end
    end
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    step();
    step();
    abort = 1'b0;
    total++;
    if (aborted !== 1'b0 || req_ready !== 1'b1 || total_cost !== 7'd5) begin
      bad++;
      $display("FAIL abort_idle: abt=%b rdy=%b cost=%0d want 0/1/5", aborted, req_ready, total_cost);
    end
  endtask

  task automatic test_reset_mid();
    send(6'b111111);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, busy, svc_active, time_left, done, aborted} !== {1'b1, 1'b0, 6'b0, 3'd0, 1'b0, 1'b0}
        || total_cost !== 7'd0 || total_time !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid: rdy=%b busy=%b act=%b tl=%0d done=%b abt=%b cost=%0d time=%0d want reset values",
               req_ready, busy, svc_active, time_left, done, aborted, total_cost, total_time);
    end
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      total++;
      if (done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_quiet: done=%b abt=%b busy=%b want 0/0/0", done, aborted, busy);
      end
    end
    send(6'b010000);
    total++;
    if (svc_active !== 6'b010000 || time_left !== 3'd3) begin
      bad++;
      $display("FAIL reset_next_run: act=%b tl=%0d want 010000/3", svc_active, time_left);
    end
    repeat (4) step();
    total++;
    if (done !== 1'b1 || total_cost !== 7'd20 || total_time !== 5'd3) begin
      bad++;
      $display("FAIL reset_next_done: done=%b cost=%0d time=%0d want 1/20/3", done, total_cost, total_time);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_sel   = '0;
    abort     = 1'b0;
    test_reset();
    test_zero_mask();
    test_single_ignore();
    test_all_services();
    test_abort_mid();
    test_abort_last();
    test_abort_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
